// File: rtl/sap1_pkg.sv
// Shared SAP-1 controller constants: opcodes, control-word bit indices and
// the fixed strobe patterns emitted by the sequencer.
package sap1_pkg;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   localparam int unsigned CW_CP   = 11;
   localparam int unsigned CW_EP   = 10;
   localparam int unsigned CW_LM_N = 9;
   localparam int unsigned CW_CE_N = 8;
   localparam int unsigned CW_LI_N = 7;
   localparam int unsigned CW_EI_N = 6;
   localparam int unsigned CW_LA_N = 5;
   localparam int unsigned CW_EA   = 4;
   localparam int unsigned CW_SU   = 3;
   localparam int unsigned CW_EU   = 2;
   localparam int unsigned CW_LB_N = 1;
   localparam int unsigned CW_LO_N = 0;

   // All active-low strobes high, all active-high strobes low.
   localparam logic [11:0] CW_INACTIVE = 12'h3E3;

   localparam logic [11:0] CW_T1 = 12'h5E3;
   localparam logic [11:0] CW_T2 = 12'hBE3;
   localparam logic [11:0] CW_T3 = 12'h263;

   localparam logic [11:0] CW_T4_MEM = 12'h1A3;
   localparam logic [11:0] CW_T4_OUT = 12'h3F2;
   localparam logic [11:0] CW_T5_LDA = 12'h2C3;
   localparam logic [11:0] CW_T5_ALU = 12'h2E1;
   localparam logic [11:0] CW_T6_ADD = 12'h3C7;
   localparam logic [11:0] CW_T6_SUB = 12'h3CF;

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring for the SAP-1 sequencer; holds while en is low and
// falls back to T1 from any non-one-hot value.
module sap1_ring_counter #(
   parameter int unsigned T_N = 6
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           en,
   output logic [T_N-1:0] t_state
);

   localparam logic [T_N-1:0] T_FIRST = {{(T_N-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (clr) begin
         t_state <= T_FIRST;
      end else if (!$onehot(t_state)) begin
         t_state <= T_FIRST;
      end else if (en) begin
         t_state <= {t_state[T_N-2:0], t_state[T_N-1]};
      end
   end

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control unit: decodes the T-state and IR opcode into the 12-bit
// control word and latches the halt flag on HLT.
module sap1_controller_sequencer
   import sap1_pkg::*;
#(
   parameter int unsigned OPC_W = 4,
   parameter int unsigned CW_W  = 12,
   parameter int unsigned T_N   = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [OPC_W-1:0] opcode,
   output logic [CW_W-1:0]  con,
   output logic [T_N-1:0]   t_state,
   output logic             hlt
);

   localparam logic [5:0] ST_T1 = 6'b000001;
   localparam logic [5:0] ST_T2 = 6'b000010;
   localparam logic [5:0] ST_T3 = 6'b000100;
   localparam logic [5:0] ST_T4 = 6'b001000;
   localparam logic [5:0] ST_T5 = 6'b010000;
   localparam logic [5:0] ST_T6 = 6'b100000;

   logic        halt_set;
   logic        ring_en;
   logic [11:0] con_dec;

   assign halt_set = !clr && !hlt && (t_state == ST_T4) && (opcode == OP_HLT);
   // The HLT edge itself must not advance the ring, so T4 is held.
   assign ring_en  = !(hlt || halt_set);

   sap1_ring_counter #(
      .T_N(T_N)
   ) u_ring (
      .clk    (clk),
      .clr    (clr),
      .en     (ring_en),
      .t_state(t_state)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         hlt <= 1'b0;
      end else if (halt_set) begin
         hlt <= 1'b1;
      end
   end

   always_comb begin
      con_dec = CW_INACTIVE;
      case (t_state)
         ST_T1: con_dec = CW_T1;
         ST_T2: con_dec = CW_T2;
         ST_T3: con_dec = CW_T3;
         ST_T4: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB: con_dec = CW_T4_MEM;
               OP_OUT:                 con_dec = CW_T4_OUT;
               default:                con_dec = CW_INACTIVE;
            endcase
         end
         ST_T5: begin
            case (opcode)
               OP_LDA:         con_dec = CW_T5_LDA;
               OP_ADD, OP_SUB: con_dec = CW_T5_ALU;
               default:        con_dec = CW_INACTIVE;
            endcase
         end
         ST_T6: begin
            case (opcode)
               OP_ADD:  con_dec = CW_T6_ADD;
               OP_SUB:  con_dec = CW_T6_SUB;
               default: con_dec = CW_INACTIVE;
            endcase
         end
         default: con_dec = CW_INACTIVE;
      endcase
   end

   // clr gates the word immediately so an aborted instruction emits no strobe.
   assign con = (clr || hlt) ? CW_INACTIVE : con_dec;

endmodule
